// File: rtl/ctl_pkg.sv
`default_nettype none
//============================================================================
// Module   : ctl_pkg
// Purpose  : Shared definitions for the EBOX register-control block:
//            AR/ARX mux select codes, MQ select codes and the state
//            encoding of the multi-precision (long) AD sequencer.
// Ports    : none (package)
// Revision : 1.0  initial release
//============================================================================
package ctl_pkg;

   // ARL / ARR / ARXL / ARXR mux select codes
   localparam logic [2:0] SEL_AR     = 3'd0;
   localparam logic [2:0] SEL_CACHE  = 3'd1;
   localparam logic [2:0] SEL_AD     = 3'd2;
   localparam logic [2:0] SEL_EBUS   = 3'd3;
   localparam logic [2:0] SEL_SH     = 3'd4;
   localparam logic [2:0] SEL_ADX    = 3'd5;
   localparam logic [2:0] SEL_ADx2   = 3'd6;
   localparam logic [2:0] SEL_ADdiv4 = 3'd7;

   // MQ / MQM select codes
   localparam logic [1:0] MQSEL_MQ     = 2'd0;
   localparam logic [1:0] MQSEL_SH     = 2'd1;
   localparam logic [1:0] MQSEL_MQx2   = 2'd2;
   localparam logic [1:0] MQSEL_MQdiv4 = 2'd3;

   // Long AD operation sequencer states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } long_state_e;

endpackage
`default_nettype wire

// File: rtl/ctl_long_seq.sv
`default_nettype none
//============================================================================
// Module   : ctl_long_seq
// Purpose  : Sequencer for multi-precision AD operations of LONG_WORDS
//            words. Holds the IDLE/RUN state, the word counter and the
//            carry-in mux that chooses between the microcode carry term
//            (first word) and the ADX carry-out of the previous word.
// Ports    : clk, rst_n       clock, asynchronous active-low reset
//            valid            microword valid this cycle
//            start            long operation requested (already valid-gated)
//            normal_carry     carry term for a non-long cycle
//            adx_carry_out    ADX bit 0 carry-out of the current word
//            ad_long          long operation active (registered)
//            long_last        final word of the long operation (registered)
//            carry            selected carry into ADX bit 35 (registered)
// Revision : 1.0  initial release
//============================================================================
module ctl_long_seq
   import ctl_pkg::*;
#(
   parameter int LONG_WORDS = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic valid,
   input  logic start,
   input  logic normal_carry,
   input  logic adx_carry_out,
   output logic ad_long,
   output logic long_last,
   output logic carry
);

   localparam int              CNT_W    = $clog2(LONG_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LONG_WORDS - 1);

   long_state_e      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             long_last_q, long_last_d;
   logic             carry_q, carry_d;
   logic             open_edge;

   // An edge may start a new operation when idle or when the final word
   // is on EDP; the latter gives back-to-back long operations with no gap.
   assign open_edge = (state_q == IDLE) || (count_q == '0);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      long_last_d = 1'b0;
      carry_d     = 1'b0;
      if (open_edge) begin
         carry_d = valid & normal_carry;
         if (start) begin
            state_d = RUN;
            count_d = CNT_INIT;
         end else begin
            state_d = IDLE;
            count_d = '0;
         end
      end else begin
         // Inside a long operation the carry chains from the previous word
         // and new start requests are ignored.
         carry_d     = adx_carry_out;
         count_d     = count_q - CNT_W'(1);
         long_last_d = (count_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         long_last_q <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         long_last_q <= long_last_d;
         carry_q     <= carry_d;
      end
   end

   assign ad_long   = (state_q == RUN);
   assign long_last = long_last_q;
   assign carry     = carry_q;

endmodule
`default_nettype wire

// File: rtl/ctl_gen.sv
`default_nettype none
//============================================================================
// Module   : ctl_gen
// Purpose  : EBOX register-control block. Registers the AR/ARX/MQ load,
//            clear and select fields of each microword into CTL_* strobes
//            for EDP, generates the ADX carry-in (suppressed on PI
//            flag-save cycles), keeps the sticky PI save-flags indication
//            and sequences long AD operations via ctl_long_seq.
// Ports    : eboxClk / eboxResetN   clock, asynchronous active-low reset
//            cr*                    CRAM field decode inputs
//            CRAM_ADcarry           microcode carry-in
//            EDP_AR                 AR contents (bit 0 used)
//            PCplus1inh             PI cycle indication
//            EDP_ADXcarryOut        ADX bit 0 carry-out
//            CTL_*                  registered load/clear/select strobes
//            ADXcarry36             carry into ADX bit 35
//            ADlong / CTL_longLast  long operation active / final word
//            CTL_PIsaveFlags        sticky PI save-flags indication
// Revision : 1.0  initial release
//============================================================================
module ctl_gen
   import ctl_pkg::*;
#(
   parameter int DATA_W     = 36,
   parameter int SEL_W      = 3,
   parameter int MQSEL_W    = 2,
   parameter int LONG_WORDS = 2
)
(
   input  logic               eboxClk,
   input  logic               eboxResetN,
   input  logic               crValid,
   input  logic [2:0]         crARload,
   input  logic [2:0]         crARclr,
   input  logic [SEL_W-1:0]   crARLsel,
   input  logic [SEL_W-1:0]   crARRsel,
   input  logic [SEL_W-1:0]   crARXLsel,
   input  logic [SEL_W-1:0]   crARXRsel,
   input  logic               crARXload,
   input  logic [MQSEL_W-1:0] crMQsel,
   input  logic [MQSEL_W-1:0] crMQMsel,
   input  logic               crMQMen,
   input  logic               crSpecXCRY,
   input  logic               crSpecLong,
   input  logic               crFlagsClr,
   input  logic               CRAM_ADcarry,
   input  logic [DATA_W-1:0]  EDP_AR,
   input  logic               PCplus1inh,
   input  logic               EDP_ADXcarryOut,
   output logic               CTL_AR00to08load,
   output logic               CTL_AR09to17load,
   output logic               CTL_ARRload,
   output logic               CTL_AR00to11clr,
   output logic               CTL_AR12to17clr,
   output logic               CTL_ARRclr,
   output logic [SEL_W-1:0]   CTL_ARL_SEL,
   output logic [SEL_W-1:0]   CTL_ARR_SEL,
   output logic [SEL_W-1:0]   CTL_ARXL_SEL,
   output logic [SEL_W-1:0]   CTL_ARXR_SEL,
   output logic               CTL_ARX_LOAD,
   output logic               CTL_MQM_EN,
   output logic [MQSEL_W-1:0] CTL_MQ_SEL,
   output logic [MQSEL_W-1:0] CTL_MQM_SEL,
   output logic               ADXcarry36,
   output logic               ADlong,
   output logic               CTL_longLast,
   output logic               CTL_PIsaveFlags
);

   logic [2:0]         ar_load_q, ar_load_d;
   logic [2:0]         ar_clr_q, ar_clr_d;
   logic [SEL_W-1:0]   arl_sel_q, arl_sel_d;
   logic [SEL_W-1:0]   arr_sel_q, arr_sel_d;
   logic [SEL_W-1:0]   arxl_sel_q, arxl_sel_d;
   logic [SEL_W-1:0]   arxr_sel_q, arxr_sel_d;
   logic               arx_load_q, arx_load_d;
   logic               mqm_en_q, mqm_en_d;
   logic [MQSEL_W-1:0] mq_sel_q, mq_sel_d;
   logic [MQSEL_W-1:0] mqm_sel_q, mqm_sel_d;
   logic               pi_flags_q, pi_flags_d;

   logic pi_save;
   logic normal_carry;
   logic unused_ar_hi;

   // Only AR bit 0 feeds the carry logic.
   assign unused_ar_hi = ^EDP_AR[DATA_W-1:1];

   assign pi_save      = crValid & PCplus1inh & crSpecXCRY;
   assign normal_carry = ~pi_save & ((EDP_AR[0] & crSpecXCRY) ^ CRAM_ADcarry);

   always_comb begin
      ar_load_d  = 3'b000;
      ar_clr_d   = 3'b000;
      arx_load_d = 1'b0;
      mqm_en_d   = 1'b0;
      arl_sel_d  = arl_sel_q;
      arr_sel_d  = arr_sel_q;
      arxl_sel_d = arxl_sel_q;
      arxr_sel_d = arxr_sel_q;
      mq_sel_d   = mq_sel_q;
      mqm_sel_d  = mqm_sel_q;
      if (crValid) begin
         // Load and clear bits are aligned per AR section, so a clear
         // masks the load of the same section.
         ar_load_d  = crARload & ~crARclr;
         ar_clr_d   = crARclr;
         arx_load_d = crARXload;
         mqm_en_d   = crMQMen;
         arl_sel_d  = crARLsel;
         arr_sel_d  = crARRsel;
         arxl_sel_d = crARXLsel;
         arxr_sel_d = crARXRsel;
         mq_sel_d   = crMQsel;
         mqm_sel_d  = crMQMsel;
      end

      // Set has priority over clear when both happen together.
      pi_flags_d = pi_flags_q;
      if (crValid & crFlagsClr) pi_flags_d = 1'b0;
      if (pi_save)              pi_flags_d = 1'b1;
   end

   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         ar_load_q  <= '0;
         ar_clr_q   <= '0;
         arl_sel_q  <= '0;
         arr_sel_q  <= '0;
         arxl_sel_q <= '0;
         arxr_sel_q <= '0;
         arx_load_q <= 1'b0;
         mqm_en_q   <= 1'b0;
         mq_sel_q   <= '0;
         mqm_sel_q  <= '0;
         pi_flags_q <= 1'b0;
      end else begin
         ar_load_q  <= ar_load_d;
         ar_clr_q   <= ar_clr_d;
         arl_sel_q  <= arl_sel_d;
         arr_sel_q  <= arr_sel_d;
         arxl_sel_q <= arxl_sel_d;
         arxr_sel_q <= arxr_sel_d;
         arx_load_q <= arx_load_d;
         mqm_en_q   <= mqm_en_d;
         mq_sel_q   <= mq_sel_d;
         mqm_sel_q  <= mqm_sel_d;
         pi_flags_q <= pi_flags_d;
      end
   end

   ctl_long_seq #(
      .LONG_WORDS    (LONG_WORDS)
   ) u_long_seq (
      .clk           (eboxClk),
      .rst_n         (eboxResetN),
      .valid         (crValid),
      .start         (crValid & crSpecLong),
      .normal_carry  (normal_carry),
      .adx_carry_out (EDP_ADXcarryOut),
      .ad_long       (ADlong),
      .long_last     (CTL_longLast),
      .carry         (ADXcarry36)
   );

   assign CTL_AR00to08load = ar_load_q[2];
   assign CTL_AR09to17load = ar_load_q[1];
   assign CTL_ARRload      = ar_load_q[0];
   assign CTL_AR00to11clr  = ar_clr_q[2];
   assign CTL_AR12to17clr  = ar_clr_q[1];
   assign CTL_ARRclr       = ar_clr_q[0];
   assign CTL_ARL_SEL      = arl_sel_q;
   assign CTL_ARR_SEL      = arr_sel_q;
   assign CTL_ARXL_SEL     = arxl_sel_q;
   assign CTL_ARXR_SEL     = arxr_sel_q;
   assign CTL_ARX_LOAD     = arx_load_q;
   assign CTL_MQM_EN       = mqm_en_q;
   assign CTL_MQ_SEL       = mq_sel_q;
   assign CTL_MQM_SEL      = mqm_sel_q;
   assign CTL_PIsaveFlags  = pi_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_ctl_gen.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_ctl_gen
// Purpose  : Self-checking bench for ctl_gen. Two instances (LONG_WORDS=4
//            and LONG_WORDS=2) share one stimulus stream; each stimulus
//            step carries the outputs it must produce one edge later.
// Ports    : none
// Revision : 1.0  initial release
//============================================================================
module tb_ctl_gen;
   import ctl_pkg::*;

   localparam int DATA_W = 36;

   typedef struct packed {
      logic [2:0] ld;
      logic [2:0] clr;
      logic [2:0] arl;
      logic [2:0] arr;
      logic [2:0] arxl;
      logic [2:0] arxr;
      logic       arx;
      logic       mqm;
      logic [1:0] mq;
      logic [1:0] mqms;
      logic       c;
      logic       al;
      logic       ll;
      logic       ps;
   } out_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] ld;
      logic [2:0] clr;
      logic [2:0] arl;
      logic [2:0] arr;
      logic [2:0] arxl;
      logic [2:0] arxr;
      logic       arx;
      logic       mqm;
      logic [1:0] mq;
      logic [1:0] mqms;
      logic       xcry;
      logic       slong;
      logic       fclr;
      logic       adc;
      logic       ar0;
      logic       inh;
      logic       cout;
      out_t       e4;
      out_t       m4;
      out_t       e2;
      out_t       m2;
   } step_t;

   logic              eboxClk = 1'b0;
   logic              eboxResetN;
   logic              crValid;
   logic [2:0]        crARload, crARclr;
   logic [2:0]        crARLsel, crARRsel, crARXLsel, crARXRsel;
   logic              crARXload;
   logic [1:0]        crMQsel, crMQMsel;
   logic              crMQMen, crSpecXCRY, crSpecLong, crFlagsClr;
   logic              CRAM_ADcarry;
   logic [DATA_W-1:0] EDP_AR;
   logic              PCplus1inh, EDP_ADXcarryOut;

   logic [2:0] ld4, clr4, arl4, arr4, arxl4, arxr4;
   logic [1:0] mq4, mqms4;
   logic       arx4, mqm4, c4, al4, ll4, ps4;
   logic [2:0] ld2, clr2, arl2, arr2, arxl2, arxr2;
   logic [1:0] mq2, mqms2;
   logic       arx2, mqm2, c2, al2, ll2, ps2;

   step_t stim_q[$];
   step_t sb[$];
   int    n_checks = 0;
   int    n_err    = 0;

   always #5 eboxClk = ~eboxClk;

   ctl_gen #(.DATA_W(DATA_W), .SEL_W(3), .MQSEL_W(2), .LONG_WORDS(4)) dut4 (
      .eboxClk(eboxClk), .eboxResetN(eboxResetN), .crValid(crValid),
      .crARload(crARload), .crARclr(crARclr),
      .crARLsel(crARLsel), .crARRsel(crARRsel), .crARXLsel(crARXLsel), .crARXRsel(crARXRsel),
      .crARXload(crARXload), .crMQsel(crMQsel), .crMQMsel(crMQMsel), .crMQMen(crMQMen),
      .crSpecXCRY(crSpecXCRY), .crSpecLong(crSpecLong), .crFlagsClr(crFlagsClr),
      .CRAM_ADcarry(CRAM_ADcarry), .EDP_AR(EDP_AR), .PCplus1inh(PCplus1inh),
      .EDP_ADXcarryOut(EDP_ADXcarryOut),
      .CTL_AR00to08load(ld4[2]), .CTL_AR09to17load(ld4[1]), .CTL_ARRload(ld4[0]),
      .CTL_AR00to11clr(clr4[2]), .CTL_AR12to17clr(clr4[1]), .CTL_ARRclr(clr4[0]),
      .CTL_ARL_SEL(arl4), .CTL_ARR_SEL(arr4), .CTL_ARXL_SEL(arxl4), .CTL_ARXR_SEL(arxr4),
      .CTL_ARX_LOAD(arx4), .CTL_MQM_EN(mqm4), .CTL_MQ_SEL(mq4), .CTL_MQM_SEL(mqms4),
      .ADXcarry36(c4), .ADlong(al4), .CTL_longLast(ll4), .CTL_PIsaveFlags(ps4)
   );

   ctl_gen #(.DATA_W(DATA_W), .SEL_W(3), .MQSEL_W(2), .LONG_WORDS(2)) dut2 (
      .eboxClk(eboxClk), .eboxResetN(eboxResetN), .crValid(crValid),
      .crARload(crARload), .crARclr(crARclr),
      .crARLsel(crARLsel), .crARRsel(crARRsel), .crARXLsel(crARXLsel), .crARXRsel(crARXRsel),
      .crARXload(crARXload), .crMQsel(crMQsel), .crMQMsel(crMQMsel), .crMQMen(crMQMen),
      .crSpecXCRY(crSpecXCRY), .crSpecLong(crSpecLong), .crFlagsClr(crFlagsClr),
      .CRAM_ADcarry(CRAM_ADcarry), .EDP_AR(EDP_AR), .PCplus1inh(PCplus1inh),
      .EDP_ADXcarryOut(EDP_ADXcarryOut),
      .CTL_AR00to08load(ld2[2]), .CTL_AR09to17load(ld2[1]), .CTL_ARRload(ld2[0]),
      .CTL_AR00to11clr(clr2[2]), .CTL_AR12to17clr(clr2[1]), .CTL_ARRclr(clr2[0]),
      .CTL_ARL_SEL(arl2), .CTL_ARR_SEL(arr2), .CTL_ARXL_SEL(arxl2), .CTL_ARXR_SEL(arxr2),
      .CTL_ARX_LOAD(arx2), .CTL_MQM_EN(mqm2), .CTL_MQ_SEL(mq2), .CTL_MQM_SEL(mqms2),
      .ADXcarry36(c2), .ADlong(al2), .CTL_longLast(ll2), .CTL_PIsaveFlags(ps2)
   );

   function automatic out_t obs4();
      return {ld4, clr4, arl4, arr4, arxl4, arxr4, arx4, mqm4, mq4, mqms4, c4, al4, ll4, ps4};
   endfunction

   function automatic out_t obs2();
      return {ld2, clr2, arl2, arr2, arxl2, arxr2, arx2, mqm2, mq2, mqms2, c2, al2, ll2, ps2};
   endfunction

   function automatic out_t m_long();
      out_t m;
      m    = '0;
      m.c  = 1'b1;
      m.al = 1'b1;
      m.ll = 1'b1;
      return m;
   endfunction

   function automatic out_t lng(input logic c, input logic al, input logic ll);
      out_t o;
      o    = '0;
      o.c  = c;
      o.al = al;
      o.ll = ll;
      return o;
   endfunction

   task automatic apply(input step_t s);
      crValid         = s.valid;
      crARload        = s.ld;
      crARclr         = s.clr;
      crARLsel        = s.arl;
      crARRsel        = s.arr;
      crARXLsel       = s.arxl;
      crARXRsel       = s.arxr;
      crARXload       = s.arx;
      crMQMen         = s.mqm;
      crMQsel         = s.mq;
      crMQMsel        = s.mqms;
      crSpecXCRY      = s.xcry;
      crSpecLong      = s.slong;
      crFlagsClr      = s.fclr;
      CRAM_ADcarry    = s.adc;
      PCplus1inh      = s.inh;
      EDP_ADXcarryOut = s.cout;
      EDP_AR          = DATA_W'({$urandom(), $urandom()});
      EDP_AR[0]       = s.ar0;
   endtask

   // Stimulus-side microword constructor with matching full expectation.
   function automatic step_t full_step(input logic valid, input logic [2:0] ld, input logic [2:0] clr,
                                       input logic [11:0] sels, input logic arx, input logic mqm,
                                       input logic [1:0] mq, input logic [1:0] mqms, input out_t e);
      step_t s;
      s = '0;
      s.valid = valid;
      s.ld = ld;
      s.clr = clr;
      {s.arl, s.arr, s.arxl, s.arxr} = sels;
      s.arx = arx;
      s.mqm = mqm;
      s.mq = mq;
      s.mqms = mqms;
      s.e4 = e;
      s.e2 = e;
      s.m4 = '1;
      s.m2 = '1;
      return s;
   endfunction

   //-------------------------------------------------------------------------
   task automatic test_reset();
      step_t s, e;
      out_t  x;
      int    i;
      repeat (2) @(posedge eboxClk);
      #1;
      n_checks++;
      if (obs4() !== '0) begin n_err++; $display("FAIL reset_state dut4: got %h want 0", obs4()); end
      n_checks++;
      if (obs2() !== '0) begin n_err++; $display("FAIL reset_state dut2: got %h want 0", obs2()); end
      @(negedge eboxClk);
      eboxResetN = 1'b1;

      x = '{ld:3'b111, clr:3'b000, arl:SEL_ADdiv4, arr:SEL_ADdiv4, arxl:SEL_ADdiv4, arxr:SEL_ADdiv4,
            arx:1'b1, mqm:1'b1, mq:MQSEL_MQdiv4, mqms:MQSEL_MQdiv4, c:1'b0, al:1'b1, ll:1'b0, ps:1'b1};
      s = full_step(1'b1, 3'b111, 3'b000, {4{SEL_ADdiv4}}, 1'b1, 1'b1, MQSEL_MQdiv4, MQSEL_MQdiv4, x);
      s.xcry = 1'b1; s.slong = 1'b1; s.ar0 = 1'b1; s.inh = 1'b1;
      stim_q.push_back(s);
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL reset_busy[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL reset_busy[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
      end

      // Asynchronous: outputs must clear before any further clock edge.
      @(negedge eboxClk);
      eboxResetN = 1'b0;
      #1;
      n_checks++;
      if (obs4() !== '0) begin n_err++; $display("FAIL async_reset dut4: got %h want 0", obs4()); end
      n_checks++;
      if (obs2() !== '0) begin n_err++; $display("FAIL async_reset dut2: got %h want 0", obs2()); end
      apply('0);
      @(posedge eboxClk);
      @(negedge eboxClk);
      eboxResetN = 1'b1;
   endtask

   //-------------------------------------------------------------------------
   task automatic test_load_clear();
      step_t s, e;
      out_t  x;
      int    i;
      x = '{ld:3'b101, clr:3'b010, arl:SEL_AD, arr:SEL_EBUS, arxl:SEL_SH, arxr:SEL_ADX,
            arx:1'b1, mqm:1'b1, mq:MQSEL_MQx2, mqms:MQSEL_SH, c:1'b0, al:1'b0, ll:1'b0, ps:1'b0};
      stim_q.push_back(full_step(1'b1, 3'b111, 3'b010, {SEL_AD, SEL_EBUS, SEL_SH, SEL_ADX},
                                 1'b1, 1'b1, MQSEL_MQx2, MQSEL_SH, x));
      // Invalid word: strobes drop, selects hold, carry gated off in IDLE.
      x.ld = 3'b000; x.clr = 3'b000; x.arx = 1'b0; x.mqm = 1'b0;
      s = full_step(1'b0, 3'b111, 3'b000, {4{SEL_CACHE}}, 1'b1, 1'b1, MQSEL_MQdiv4, MQSEL_MQdiv4, x);
      s.xcry = 1'b1; s.ar0 = 1'b1; s.inh = 1'b1; s.slong = 1'b1;
      stim_q.push_back(s);
      x = '{ld:3'b000, clr:3'b111, arl:SEL_ADx2, arr:SEL_CACHE, arxl:SEL_AR, arxr:SEL_ADdiv4,
            arx:1'b0, mqm:1'b1, mq:MQSEL_MQ, mqms:MQSEL_MQdiv4, c:1'b0, al:1'b0, ll:1'b0, ps:1'b0};
      stim_q.push_back(full_step(1'b1, 3'b111, 3'b111, {SEL_ADx2, SEL_CACHE, SEL_AR, SEL_ADdiv4},
                                 1'b0, 1'b1, MQSEL_MQ, MQSEL_MQdiv4, x));
      x.ld = 3'b011; x.clr = 3'b100; x.arx = 1'b1; x.mqm = 1'b0;
      stim_q.push_back(full_step(1'b1, 3'b011, 3'b100, {SEL_ADx2, SEL_CACHE, SEL_AR, SEL_ADdiv4},
                                 1'b1, 1'b0, MQSEL_MQ, MQSEL_MQdiv4, x));
      x.ld = 3'b100; x.clr = 3'b001;
      stim_q.push_back(full_step(1'b1, 3'b101, 3'b001, {SEL_ADx2, SEL_CACHE, SEL_AR, SEL_ADdiv4},
                                 1'b1, 1'b0, MQSEL_MQ, MQSEL_MQdiv4, x));
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL load_clear[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL load_clear[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
      end
   endtask

   //-------------------------------------------------------------------------
   task automatic test_carry();
      step_t s, e;
      // {valid, ar0, xcry, adc, inh, fclr, expected carry, expected sticky}
      logic [7:0] tbl [10];
      int    i;
      tbl = '{8'b1_1_1_0_0_0_1_0, 8'b1_1_1_1_0_0_0_0, 8'b1_0_1_1_0_0_1_0, 8'b1_1_0_1_0_0_1_0,
              8'b1_1_1_0_1_0_0_1, 8'b1_0_0_1_1_0_1_1, 8'b0_0_0_0_0_1_0_1, 8'b1_0_0_0_0_1_0_0,
              8'b1_1_1_0_1_1_0_1, 8'b1_0_0_0_0_1_0_0};
      for (int k = 0; k < 10; k++) begin
         s = '0;
         {s.valid, s.ar0, s.xcry, s.adc, s.inh, s.fclr, s.e4.c, s.e4.ps} = tbl[k];
         s.m4.c = 1'b1; s.m4.ps = 1'b1; s.m4.al = 1'b1;
         s.e2 = s.e4;
         s.m2 = s.m4;
         stim_q.push_back(s);
      end
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL carry[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL carry[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
      end
   endtask

   //-------------------------------------------------------------------------
   task automatic test_long();
      step_t s, e;
      int    i;
      // {valid, slong, adc, cout, e4 c/al/ll, e2 c/al/ll}
      logic [9:0] tbl [5];
      tbl = '{10'b1_1_1_0_110_110, 10'b0_0_0_1_110_111, 10'b0_0_0_0_010_000,
              10'b0_0_0_1_111_000, 10'b0_0_0_1_000_000};
      for (int k = 0; k < 5; k++) begin
         s = '0;
         {s.valid, s.slong, s.adc, s.cout} = tbl[k][9:6];
         s.e4 = lng(tbl[k][5], tbl[k][4], tbl[k][3]);
         s.e2 = lng(tbl[k][2], tbl[k][1], tbl[k][0]);
         s.m4 = m_long();
         s.m2 = m_long();
         if (k == 1) begin
            // PI save-flags word inside RUN: carry still chains, flag sets.
            s.valid = 1'b1; s.inh = 1'b1; s.xcry = 1'b1; s.ar0 = 1'b1; s.slong = 1'b1;
            s.e4.ps = 1'b1; s.e2.ps = 1'b1; s.m4.ps = 1'b1; s.m2.ps = 1'b1;
         end
         stim_q.push_back(s);
      end
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL long[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL long[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
      end
   endtask

   //-------------------------------------------------------------------------
   task automatic test_back_to_back();
      step_t s, e;
      int    i;
      // {valid, slong, adc, xcry&ar0, cout, e4 c/al/ll, e2 c/al/ll}
      logic [10:0] tbl [9];
      tbl = '{11'b1_1_0_0_0_010_010, 11'b1_1_1_0_1_110_111, 11'b1_1_1_0_0_010_110,
              11'b0_0_0_0_1_111_111, 11'b1_1_0_1_0_110_110, 11'b0_0_0_0_0_010_011,
              11'b0_0_0_0_1_110_000, 11'b0_0_0_0_0_011_000, 11'b0_0_0_0_0_000_000};
      for (int k = 0; k < 9; k++) begin
         s = '0;
         {s.valid, s.slong, s.adc, s.xcry, s.cout} = tbl[k][10:6];
         s.ar0 = s.xcry;
         s.e4 = lng(tbl[k][5], tbl[k][4], tbl[k][3]);
         s.e2 = lng(tbl[k][2], tbl[k][1], tbl[k][0]);
         s.m4 = m_long();
         s.m2 = m_long();
         if (k == 1) begin
            // Fields of a word issued mid-operation are still accepted.
            s.ld = 3'b001;
            s.e4.ld = 3'b001; s.e2.ld = 3'b001;
            s.m4.ld = 3'b111; s.m2.ld = 3'b111;
         end
         stim_q.push_back(s);
      end
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL back_to_back[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL back_to_back[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
      end
   endtask

   //-------------------------------------------------------------------------
   task automatic test_reset_mid_run();
      step_t s, e;
      int    i;
      // {valid, slong, adc, cout, e4 c/al/ll, e2 c/al/ll}
      logic [9:0] tbl [7];
      tbl = '{10'b1_1_1_0_110_110, 10'b0_0_0_0_010_011,
              10'b1_1_1_0_110_110, 10'b0_0_0_0_010_011, 10'b0_0_0_0_010_000,
              10'b0_0_0_0_011_000, 10'b0_0_0_0_000_000};
      for (int k = 0; k < 7; k++) begin
         s = '0;
         {s.valid, s.slong, s.adc, s.cout} = tbl[k][9:6];
         s.e4 = lng(tbl[k][5], tbl[k][4], tbl[k][3]);
         s.e2 = lng(tbl[k][2], tbl[k][1], tbl[k][0]);
         s.m4 = m_long();
         s.m2 = m_long();
         stim_q.push_back(s);
      end
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         sb.push_back(s);
         @(posedge eboxClk); #1;
         e = sb.pop_front();
         n_checks++;
         if (((obs4() ^ e.e4) & e.m4) !== '0) begin
            n_err++; $display("FAIL reset_mid_run[%0d] dut4: got %h want %h mask %h", i, obs4() & e.m4, e.e4 & e.m4, e.m4);
         end
         n_checks++;
         if (((obs2() ^ e.e2) & e.m2) !== '0) begin
            n_err++; $display("FAIL reset_mid_run[%0d] dut2: got %h want %h mask %h", i, obs2() & e.m2, e.e2 & e.m2, e.m2);
         end
         i++;
         if (i == 2) begin
            // Abort the 4-word operation at t+2, between clock edges.
            @(negedge eboxClk);
            eboxResetN = 1'b0;
            #1;
            n_checks++;
            if (obs4() !== '0) begin n_err++; $display("FAIL abort_run dut4: got %h want 0", obs4()); end
            n_checks++;
            if (obs2() !== '0) begin n_err++; $display("FAIL abort_run dut2: got %h want 0", obs2()); end
            @(posedge eboxClk);
            @(negedge eboxClk);
            eboxResetN = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      apply('0);
      eboxResetN = 1'b0;
      test_reset();
      test_load_clear();
      test_carry();
      test_long();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
